// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM encoding, tag byte base
// and a ceiling-log2 helper used to size index and counter fields.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        XFER = 2'd1,
        HOLD = 2'd2,
        TAG  = 2'd3
    } arb_state_t;

    // ASCII '0'; the tag byte for requester i is TAG_BASE + i.
    localparam logic [7:0] TAG_BASE = 8'h30;

    // Ceiling log2, never below 1 so that single-bit fields stay legal.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int r = 1; r < 31; r++) begin
            if ((32'd1 << r) < value) begin
                result = r + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set request bit scanning
// last_idx+1, last_idx+2, ... modulo N. Reusable by any shared-resource arbiter.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Walk from the lowest priority upwards so the highest-priority hit wins last.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last_idx) + k) % N);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx between N
// byte-stream requesters. Grant is held until a byte flagged last, or until
// the owner leaves req_valid low for TIMEOUT cycles in XFER.
// Optional build macro UART_ARB_TAG_EN: each message is prefixed with the
// ASCII digit of the owner's index ('0' + idx).
//
// Handshake: a byte from requester i moves when req_valid[i] && req_ready[i]
// at a rising clk edge; req_data/req_last must hold while req_valid is high.
// req_ready is combinational and only high in XFER for the owner while
// uart_tx reports ready. tx_write is a one-cycle registered strobe.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic           timeout,
    output logic [7:0]     tx_data,
    output logic           tx_write,
    input  logic           tx_ready,
    output logic [1:0]     fsm_state
);

    localparam int IW = clog2(N);
    localparam int CW = clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(N - 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

    arb_state_t    state, state_n;
    logic [N-1:0]  grant_n;
    logic [IW-1:0] last_idx, last_idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    tx_data_n;
    logic          tx_write_n, timeout_n;
    logic          last_reg, last_reg_n;

    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          cur_valid, cur_last;
    logic [7:0]    cur_data;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req      (req_valid),
        .last_idx (last_idx),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    // While granted, last_idx names the owner, so it selects the owner's lane.
    assign cur_valid = req_valid[last_idx];
    assign cur_last  = req_last[last_idx];
    assign cur_data  = req_data[{last_idx, 3'b000} +: 8];

    // Reset is gated in so a byte offered during reset is never seen as taken.
    assign req_ready = (state == XFER && tx_ready && !reset) ? grant : '0;
    assign fsm_state = state;

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        last_idx_n = last_idx;
        cnt_n      = cnt;
        tx_data_n  = tx_data;
        tx_write_n = 1'b0;
        timeout_n  = 1'b0;
        last_reg_n = last_reg;
        case (state)
            ARB: begin
                if (pick_any) begin
                    grant_n    = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    last_idx_n = pick_idx;
                    cnt_n      = '0;
`ifdef UART_ARB_TAG_EN
                    state_n    = TAG;
`else
                    state_n    = XFER;
`endif
                end
            end
            XFER: begin
                if (cur_valid && tx_ready) begin
                    tx_data_n  = cur_data;
                    tx_write_n = 1'b1;
                    cnt_n      = '0;
                    last_reg_n = cur_last;
                    state_n    = HOLD;
                end else if (!cur_valid) begin
                    if (cnt == CNT_LIMIT) begin
                        timeout_n = 1'b1;
                        grant_n   = '0;
                        state_n   = ARB;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            HOLD: begin
                // uart_tx drops ready a cycle after write, so ready is not sampled here.
                if (last_reg) begin
                    grant_n = '0;
                    state_n = ARB;
                end else begin
                    state_n = XFER;
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                if (tx_ready) begin
                    tx_data_n  = TAG_BASE + {{(8-IW){1'b0}}, last_idx};
                    tx_write_n = 1'b1;
                    last_reg_n = 1'b0;
                    state_n    = HOLD;
                end
            end
`endif
            default: begin
                grant_n = '0;
                state_n = ARB;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            grant    <= '0;
            last_idx <= LAST_INIT;
            cnt      <= '0;
            tx_data  <= '0;
            tx_write <= 1'b0;
            timeout  <= 1'b0;
            last_reg <= 1'b0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            last_idx <= last_idx_n;
            cnt      <= cnt_n;
            tx_data  <= tx_data_n;
            tx_write <= tx_write_n;
            timeout  <= timeout_n;
            last_reg <= last_reg_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (N=4, TIMEOUT=10) with a uart_tx ready model.
// Honours UART_ARB_TAG_EN so expected byte streams include tag bytes.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        timeout;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_ready;
    logic [1:0]  fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_len = 4;
    bit force_low = 0;
    int exp_owner = -1;
    logic [7:0] tx_log[$];
    logic [7:0] exp_q[$];

    uart_tx_arbiter #(.N(4), .TIMEOUT(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .timeout   (timeout),
        .tx_data   (tx_data),
        .tx_write  (tx_write),
        .tx_ready  (tx_ready),
        .fsm_state (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int owner_of(input logic [3:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    // uart_tx model: ready drops the cycle after a write and stays low busy_len cycles.
    initial begin
        int busy;
        logic w;
        busy = 0;
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            w = tx_write;
            @(posedge clk);
            #1;
            if (w) busy = busy_len;
            else if (busy > 0) busy--;
            tx_ready = (busy == 0) && !force_low;
        end
    end

    // Per-cycle compare: every accepted byte must be written next cycle, nothing else may be.
    initial begin
        logic       exp_valid;
        logic [7:0] exp_byte;
        logic       prev_ready;
        logic [3:0] acc;
        exp_valid = 1'b0;
        exp_byte = '0;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_valid = 1'b0;
            end else begin
                if (tx_write) tx_log.push_back(tx_data);
                if (exp_valid) begin
                    chk("tx_byte", 32'({tx_write, tx_data}), 32'({1'b1, exp_byte}));
                end else if (tx_write) begin
`ifdef UART_ARB_TAG_EN
                    chk("tag_byte", 32'(tx_data), 32'h30 + 32'(owner_of(grant)));
`else
                    chk("spurious_write", 32'(tx_write), 32'd0);
`endif
                end
                if (tx_write) chk("write_needs_ready", 32'(prev_ready), 32'd1);
                chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                chk("ready_in_grant", 32'(req_ready & ~(grant & {4{tx_ready}})), 32'd0);
                if (exp_owner >= 0) chk("grant_owner", 32'(grant), 32'(4'b0001 << exp_owner));
                acc = req_valid & req_ready;
                chk("single_accept", 32'($countones(acc) <= 1), 32'd1);
                exp_valid = |acc;
                for (int i = 0; i < 4; i++) if (acc[i]) exp_byte = req_data[8*i +: 8];
            end
            prev_ready = tx_ready;
        end
    end

    // Driver tasks
    task automatic drive(input int i, input logic [7:0] d, input logic l);
        req_data[8*i +: 8] = d;
        req_last[i] = l;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_accept(input int i);
        int n;
        bit got;
        n = 0;
        got = 0;
        while (!got && n < 600) begin
            @(negedge clk);
            if (req_valid[i] && req_ready[i]) got = 1;
            else n++;
        end
        chk($sformatf("accept_%0d", i), 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // bytes[7:0] goes first; last flag on byte n-1 when with_last is set.
    task automatic send_msg(input int i, input logic [31:0] bytes, input int n, input bit with_last);
        for (int k = 0; k < n; k++) begin
            drive(i, bytes[8*k +: 8], with_last && (k == n - 1));
            wait_accept(i);
        end
        req_valid[i] = 1'b0;
        req_last[i] = 1'b0;
    endtask

    task automatic push_msg(input int i, input logic [31:0] bytes, input int n);
`ifdef UART_ARB_TAG_EN
        exp_q.push_back(8'(32'h30 + i));
`endif
        for (int k = 0; k < n; k++) exp_q.push_back(bytes[8*k +: 8]);
    endtask

    task automatic check_log(input string name);
        chk({name, "_count"}, 32'(tx_log.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < tx_log.size(); k++)
            chk($sformatf("%s_byte%0d", name, k), 32'(tx_log[k]), 32'(exp_q[k]));
        tx_log.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_valid = '0;
        req_last = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Watchdog
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    // Directed tests
    initial begin
        int k;
        bit seen;
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tx_write", 32'(tx_write), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'(ARB));
        #1 reset = 1'b0;

        // 1: single requester, slow uart, three bytes under one grant.
        busy_len = 160;
        tx_log.delete();
        push_msg(1, 32'h00434241, 3);
        @(posedge clk);
        #1;
        fork
            send_msg(1, 32'h00434241, 3, 1);
            begin @(negedge clk); #1; exp_owner = 1; end
        join
        @(negedge clk);
        #1 exp_owner = -1;
        @(negedge clk);
        chk("t1_grant_released", 32'(grant), 32'd0);
        check_log("t1");
        repeat (170) @(posedge clk);
        busy_len = 4;

        // 2: 0 and 2 contend from last_idx=3; 0 re-requests right after, 2 wins that.
        do_reset();
        tx_log.delete();
        push_msg(0, 32'h00000201, 2);
        push_msg(2, 32'h0000C2C1, 2);
        push_msg(0, 32'h00000403, 2);
        fork
            begin
                send_msg(0, 32'h00000201, 2, 1);
                send_msg(0, 32'h00000403, 2, 1);
            end
            send_msg(2, 32'h0000C2C1, 2, 1);
        join
        repeat (5) @(posedge clk);
        check_log("t2");

        // 3: requester 3 stalls mid-message, timeout revokes, pending 1 takes over.
        do_reset();
        tx_log.delete();
        push_msg(3, 32'h0000005A, 1);
        push_msg(1, 32'h00000061, 1);
        drive(3, 8'h5A, 1'b0);
        wait_accept(3);
        req_valid[3] = 1'b0;
        drive(1, 8'h61, 1'b1);
        @(negedge clk);
        chk("t3_hold_write", 32'(tx_write), 32'd1);
        k = 0;
        seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (timeout) seen = 1;
        end
        chk("t3_timeout_delay", 32'(k), 32'd11);
        chk("t3_grant_dropped", 32'(grant), 32'd0);
        fork
            wait_accept(1);
            begin
                @(negedge clk);
                chk("t3_timeout_pulse", 32'(timeout), 32'd0);
                chk("t3_next_grant", 32'(grant), 32'b0010);
            end
        join
        req_valid[1] = 1'b0;
        req_last[1] = 1'b0;
        repeat (5) @(posedge clk);
        check_log("t3");

        // 4: reset in HOLD mid-message, then a clean message.
        do_reset();
        tx_log.delete();
        push_msg(0, 32'h00000011, 1);
        push_msg(0, 32'h00002221, 2);
        drive(0, 8'h11, 1'b0);
        wait_accept(0);
        @(negedge clk);
        chk("t4_hold_write", 32'(tx_write), 32'd1);
        #1;
        reset = 1'b1;
        req_valid = '0;
        req_last = '0;
        @(negedge clk);
        chk("t4_grant", 32'(grant), 32'd0);
        chk("t4_tx_write", 32'(tx_write), 32'd0);
        chk("t4_state", 32'(fsm_state), 32'(ARB));
        chk("t4_req_ready", 32'(req_ready), 32'd0);
        #1 reset = 1'b0;
        send_msg(0, 32'h00002221, 2, 1);
        repeat (5) @(posedge clk);
        check_log("t4");

        // 5: uart not ready for 50 cycles while valid is high: no stall, no write.
        do_reset();
        tx_log.delete();
        push_msg(2, 32'h00000077, 1);
        force_low = 1'b1;
        tx_ready = 1'b0;
        drive(2, 8'h77, 1'b1);
        repeat (50) begin
            @(negedge clk);
            chk("t5_quiet", 32'({timeout, tx_write, req_ready}), 32'd0);
        end
        chk("t5_grant_held", 32'(grant), 32'b0100);
        #1 force_low = 1'b0;
        wait_accept(2);
        req_valid[2] = 1'b0;
        req_last[2] = 1'b0;
        repeat (5) @(posedge clk);
        check_log("t5");

        // 6: requester 2 sends one byte with last.
        do_reset();
        tx_log.delete();
        push_msg(2, 32'h00000055, 1);
        send_msg(2, 32'h00000055, 1, 1);
        repeat (5) @(posedge clk);
`ifdef UART_ARB_TAG_EN
        chk("t6_tag_first", 32'(tx_log.size() > 0 ? tx_log[0] : 8'h00), 32'h32);
`endif
        check_log("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
